data_mem: RTL and testbench

//  Data memory of the single-cycle MIPS core, directly downstream of the ALU. The ALU

---
 rtl/mips_defs.sv | 18 +
 rtl/mem_ext.sv | 57 +++++
 rtl/data_mem.sv | 67 ++++++
 tb/tb_data_mem.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the single-cycle MIPS core: memory access codes and sizing.
package mips_defs;

    localparam int MEM_WORDS_DEF = 1024;

    typedef enum logic [2:0] {
        MEM_W  = 3'd0,
        MEM_H  = 3'd1,
        MEM_HU = 3'd2,
        MEM_B  = 3'd3,
        MEM_BU = 3'd4
    } mem_op_t;

    function automatic logic op_valid(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

endpackage

// File: rtl/mem_ext.sv
// Pure combinational load extraction/extension and store byte-lane merge for data_mem.
module mem_ext
    import mips_defs::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  mem_op,
    output logic [31:0] rdata,
    output logic [31:0] merged,
    output logic [3:0]  lane_mask
);

    logic [15:0] half;
    logic [7:0]  byte_val;

    assign half     = offset[1] ? word[31:16] : word[15:0];
    assign byte_val = word[8*offset +: 8];

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        rdata = 32'h0;
        case (mem_op)
            MEM_W:   rdata = word;
            MEM_H:   rdata = {{16{half[15]}}, half};
            MEM_HU:  rdata = {16'h0, half};
            MEM_B:   rdata = {{24{byte_val[7]}}, byte_val};
            MEM_BU:  rdata = {24'h0, byte_val};
            default: rdata = 32'h0;
        endcase
    end

    always_comb begin
        lane_mask = 4'b0000;
        merged    = word;
        case (mem_op)
            MEM_W: begin
                lane_mask = 4'b1111;
                merged    = wdata;
            end
            MEM_H, MEM_HU: begin
                lane_mask = offset[1] ? 4'b1100 : 4'b0011;
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
            end
            MEM_B, MEM_BU: begin
                lane_mask             = 4'b0001 << offset;
                merged[8*offset +: 8] = wdata[7:0];
            end
            default: begin
                lane_mask = 4'b0000;
                merged    = word;
            end
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Data memory of the single-cycle MIPS core: combinational loads, clocked byte-lane stores,
// misalignment/range flagging and a per-store log line.
module data_mem
    import mips_defs::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [2:0]  mem_op,
    output logic [31:0] rdata,
    output logic        addr_err
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    logic [31:0]      mem [0:MEM_WORDS-1];
    logic [IDX_W-1:0] idx;
    logic [31:0]      word;
    logic [31:0]      ext_rdata;
    logic [31:0]      merged;
    logic [3:0]       lane_mask;

    assign idx  = addr[IDX_W+1:2];
    assign word = mem[idx];

    always_comb begin
        addr_err = 1'b0;
        if (addr >= ADDR_LIMIT)                      addr_err = 1'b1;
        if (!op_valid(mem_op))                       addr_err = 1'b1;
        if (mem_op == MEM_W && addr[1:0] != 2'b00)   addr_err = 1'b1;
        if ((mem_op == MEM_H || mem_op == MEM_HU) && addr[0]) addr_err = 1'b1;
    end

    mem_ext u_mem_ext (
        .word      (word),
        .wdata     (wdata),
        .offset    (addr[1:0]),
        .mem_op    (mem_op),
        .rdata     (ext_rdata),
        .merged    (merged),
        .lane_mask (lane_mask)
    );

    assign rdata = addr_err ? 32'h0 : ext_rdata;

    // NOTE: the array is cleared on reset because the core relies on loads returning 0
    // after reset; this costs a flop-based array rather than an inferred RAM macro.
    // NOTE: all state here uses non-blocking assignments so loads see the old word until the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h0;
        end else if (we && !addr_err) begin
            for (int l = 0; l < 4; l++)
                if (lane_mask[l]) mem[idx][8*l +: 8] <= merged[8*l +: 8];
`ifndef SYNTHESIS
            $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
`endif
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem with hand-computed expected values.
module tb_data_mem;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  mem_op;
    logic [31:0] rdata;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    data_mem dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .mem_op   (mem_op),
        .rdata    (rdata),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a store at the falling edge, let it commit on the next rising edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op,
                         input logic exp_err, input string tag);
        @(negedge clk);
        pc = pc + 32'd4; addr = a; wdata = d; mem_op = op; we = 1'b1;
        #1;
        check({tag, "_err"}, {31'h0, addr_err}, {31'h0, exp_err});
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] op, input logic [31:0] exp,
                        input logic exp_err, input string tag);
        @(negedge clk);
        we = 1'b0; addr = a; mem_op = op;
        #1;
        check(tag, rdata, exp);
        check({tag, "_err"}, {31'h0, addr_err}, {31'h0, exp_err});
    endtask

    initial begin
        reset = 1'b0; pc = 32'h0040_0000; addr = '0; wdata = '0; we = 1'b0; mem_op = MEM_W;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Reset clears earlier stores
        store(32'h0, 32'hDEAD_BEEF, MEM_W, 1'b0, "pre_sw0");
        store(32'h10, 32'h1234_5678, MEM_W, 1'b0, "pre_sw10");
        store(32'hFFC, 32'hA5A5_A5A5, MEM_W, 1'b0, "pre_swffc");
        load(32'hFFC, MEM_W, 32'hA5A5_A5A5, 1'b0, "lw_ffc_pre");
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        load(32'h0,   MEM_W, 32'h0, 1'b0, "rst_lw0");
        load(32'h10,  MEM_W, 32'h0, 1'b0, "rst_lw10");
        load(32'hFFC, MEM_W, 32'h0, 1'b0, "rst_lwffc");

        // Word store/load
        store(32'h8, 32'h1234_5678, MEM_W, 1'b0, "sw8");
        load(32'h8, MEM_W, 32'h1234_5678, 1'b0, "lw8");

        // Byte/half merge and extension
        store(32'h9, 32'h0000_00AB, MEM_B, 1'b0, "sb9");
        load(32'h8, MEM_W, 32'h1234_AB78, 1'b0, "lw8_sb");
        store(32'hA, 32'h0000_BEEF, MEM_H, 1'b0, "shA");
        load(32'h8, MEM_W, 32'hBEEF_AB78, 1'b0, "lw8_sh");
        load(32'h9, MEM_B,  32'hFFFF_FFAB, 1'b0, "lb9");
        load(32'h9, MEM_BU, 32'h0000_00AB, 1'b0, "lbu9");
        load(32'hA, MEM_H,  32'hFFFF_BEEF, 1'b0, "lhA");
        load(32'hA, MEM_HU, 32'h0000_BEEF, 1'b0, "lhuA");
        load(32'h8, MEM_HU, 32'h0000_AB78, 1'b0, "lhu8");
        load(32'hB, MEM_BU, 32'h0000_00BE, 1'b0, "lbuB");

        // Misaligned, out-of-range and undefined-op accesses
        store(32'h4, 32'hCAFE_F00D, MEM_W, 1'b0, "sw4");
        store(32'h6, 32'h1111_1111, MEM_W, 1'b1, "sw6_mis");
        store(32'h3, 32'h0000_2222, MEM_H, 1'b1, "sh3_mis");
        store(32'h8, 32'h3333_3333, 3'd5,  1'b1, "bad_op");
        load(32'h4, MEM_W, 32'hCAFE_F00D, 1'b0, "lw4_keep");
        load(32'h0, MEM_W, 32'h0, 1'b0, "lw0_keep");
        load(32'h8, MEM_W, 32'hBEEF_AB78, 1'b0, "lw8_keep");
        load(32'h1000, MEM_W, 32'h0, 1'b1, "lw_oor");
        load(32'h6, MEM_W, 32'h0, 1'b1, "lw6_mis");
        load(32'hB, MEM_H, 32'h0, 1'b1, "lhB_mis");

        // Reset wins over a same-cycle store
        @(negedge clk);
        reset = 1'b0; we = 1'b1; addr = 32'h4; wdata = 32'hFFFF_FFFF; mem_op = MEM_W;
        @(posedge clk); #1 reset = 1'b1; we = 1'b0;
        load(32'h4, MEM_W, 32'h0, 1'b0, "rst_vs_sw");

        // Back-to-back stores: old word visible until the second edge
        @(negedge clk);
        pc = pc + 32'd4; addr = 32'h0; wdata = 32'h1; mem_op = MEM_W; we = 1'b1;
        @(posedge clk); #1;
        pc = pc + 32'd4; wdata = 32'h2;
        #1 check("b2b_mid", rdata, 32'h1);
        @(posedge clk); #1 we = 1'b0;
        load(32'h0, MEM_W, 32'h2, 1'b0, "b2b_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
